// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller: stage enables, glitch-free flush flops,
// and a saturating stall-cycle counter.
module pipeline_hazard_controller #(
  parameter int REG_ADDR_W = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [REG_ADDR_W-1:0] id_rn,
  input  logic                  id_rn_valid,
  input  logic [REG_ADDR_W-1:0] id_rm,
  input  logic                  id_rm_valid,
  input  logic                  ex_load,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_branch_taken,
  input  logic                  mem_busy,
  input  logic                  halt_req,
  input  logic                  resume,
  input  logic                  clr_count,
  output logic                  en_pc,
  output logic                  en_ifid,
  output logic                  en_idex,
  output logic                  en_exmem,
  output logic                  en_memwb,
  output logic                  flush_ifid,
  output logic                  flush_idex,
  output logic                  halted,
  output logic [CNT_W-1:0]      stall_count
);

  typedef enum logic [4:0] {
    RUN     = 5'b00001,
    STALL   = 5'b00010,
    FLUSH   = 5'b00100,
    MEMWAIT = 5'b01000,
    HALT    = 5'b10000
  } state_e;

  state_e           state_q, state_d;
  logic             fl_ifid_q, fl_ifid_d;
  logic             fl_idex_q, fl_idex_d;
  logic             halt_q, halt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hz;
  logic             pc_c, ifid_c, idex_c, exmem_c, memwb_c;

  assign hz = ex_load &
              ((id_rn_valid & (id_rn == ex_rd)) |
               (id_rm_valid & (id_rm == ex_rd)));

  always_comb begin
    state_d = state_q;
    pc_c    = 1'b1;
    ifid_c  = 1'b1;
    idex_c  = 1'b1;
    exmem_c = 1'b1;
    memwb_c = 1'b1;
    unique case (state_q)
      RUN: begin
        if (ex_branch_taken) begin
          state_d = FLUSH;
        end else if (hz) begin
          state_d = STALL;
          pc_c    = 1'b0;
          ifid_c  = 1'b0;
        end else if (halt_req) begin
          state_d = HALT;
        end
      end
      STALL: begin
        state_d = RUN;
        pc_c    = 1'b0;
        ifid_c  = 1'b0;
      end
      FLUSH: begin
        state_d = RUN;
        pc_c    = 1'b0;
      end
      MEMWAIT: begin
        state_d = RUN;
        pc_c    = 1'b0;
        ifid_c  = 1'b0;
        idex_c  = 1'b0;
        exmem_c = 1'b0;
        memwb_c = 1'b0;
      end
      HALT: begin
        if (resume) state_d = RUN;
        pc_c   = 1'b0;
        ifid_c = 1'b0;
      end
      default: state_d = RUN;
    endcase
    if (mem_busy) state_d = MEMWAIT;
  end

  // Flush/halt flops are decoded from the next state so outputs are pure flop Qs
  assign fl_ifid_d = (state_d == FLUSH);
  assign fl_idex_d = (state_d == FLUSH) | (state_d == STALL);
  assign halt_d    = (state_d == HALT);

  assign en_pc    = pc_c    & ~mem_busy & reset_n;
  assign en_ifid  = ifid_c  & ~mem_busy & reset_n;
  assign en_idex  = idex_c  & ~mem_busy & reset_n;
  assign en_exmem = exmem_c & ~mem_busy & reset_n;
  assign en_memwb = memwb_c & ~mem_busy & reset_n;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_count)
      cnt_d = '0;
    else if (!en_pc && (cnt_q != '1))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= RUN;
      fl_ifid_q <= 1'b0;
      fl_idex_q <= 1'b0;
      halt_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      fl_ifid_q <= fl_ifid_d;
      fl_idex_q <= fl_idex_d;
      halt_q    <= halt_d;
      cnt_q     <= cnt_d;
    end
  end

  assign flush_ifid  = fl_ifid_q;
  assign flush_idex  = fl_idex_q;
  assign halted      = halt_q;
  assign stall_count = cnt_q;

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Central sequencer for the pipeline-register enables and clears across the IF/ID, ID/EX, EX/MEM and MEM/WB stage flops and the PC flop.
- Detects load-use hazards, taken branches, memory wait and halt requests. Drives per-stage enable lines and per-stage clear lines that connect to those flops' async clear.
- Also keeps a saturating stall-cycle counter for performance debug.

Parameters:
- REG_ADDR_W, 4, width of register-file addresses compared for load-use.
- CNT_W, 16, width of stall-cycle counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- id_rn  in  REG_ADDR_W  first source register of the instruction in decode.
- id_rn_valid  in  1  id_rn is actually read.
- id_rm  in  REG_ADDR_W  second source register of the instruction in decode.
- id_rm_valid  in  1  id_rm is actually read.
- ex_load  in  1  instruction in EX is a load.
- ex_rd  in  REG_ADDR_W  destination register of the instruction in EX.
- ex_branch_taken  in  1  branch in EX resolved taken; the datapath loads the target into PC at this edge.
- mem_busy  in  1  data memory not ready; whole pipeline must freeze.
- halt_req  in  1  request to halt issue.
- resume  in  1  leave halt.
- clr_count  in  1  synchronous clear of stall_count.
- en_pc, en_ifid, en_idex, en_exmem, en_memwb  out  1 each  stage-register enables.
- flush_ifid, flush_idex  out  1 each  stage-register clears (feed async clear of those flops).
- halted  out  1  high in HALT state.
- stall_count  out  CNT_W  saturating count of cycles with en_pc=0.

Behaviour:
- States: RUN, STALL, FLUSH, MEMWAIT, HALT. Reset state is RUN.
- Reset values:
  - flush_*=0, halted=0, stall_count=0.
  - All en_* forced 0 while reset_n=0.
- flush_ifid, flush_idex and halted are each driven directly by a flop (one-hot state bits), never by combinational decode. This makes them glitch-free for use as async clears.
- Enables are combinational from state and mem_busy.
- Hazard term: hz = ex_load & ((id_rn_valid & id_rn==ex_rd) | (id_rm_valid & id_rm==ex_rd)).
- Next-state priority, evaluated in every state: mem_busy > ex_branch_taken (RUN only) > hz (RUN only) > halt_req (RUN only).
  - mem_busy=1 in any state -> MEMWAIT.
  - RUN: ex_branch_taken -> FLUSH; else hz -> STALL; else halt_req -> HALT; else stay RUN.
  - STALL -> RUN; FLUSH -> RUN (both exactly one cycle).
  - MEMWAIT: stay while mem_busy, else RUN. Hazards are re-evaluated in RUN because the pipeline was frozen.
  - HALT: resume -> RUN; else stay. mem_busy still wins.
- Outputs per state:
  - RUN: all en=1, flushes 0. Exception: if hz and no ex_branch_taken and no mem_busy, then en_pc=en_ifid=0 in that same cycle, and en_idex=en_exmem=en_memwb stay 1.
  - STALL: en_pc=en_ifid=0, others 1; flush_idex=1 (bubble replaces the dependent instruction captured last edge), flush_ifid=0.
  - FLUSH: en_pc=0 (PC holds the branch target), en_ifid=en_idex=1, en_exmem=en_memwb=1; flush_ifid=flush_idex=1.
  - MEMWAIT: all en=0, flushes 0.
  - HALT: en_pc=en_ifid=0, en_idex=en_exmem=en_memwb=1 (pipeline drains); flushes 0; halted=1.
- Freeze override: mem_busy=1 forces all en=0 combinationally in any state. Flush flops keep their state-decoded value for that cycle.
- Penalties: load-use = 2 cycles without PC advance (detect cycle + STALL); taken branch = 1 cycle of FLUSH plus 2 killed instructions.
- stall_count:
  - Increments at an edge when en_pc=0 and reset_n=1.
  - Saturates at 2^CNT_W-1.
  - clr_count has priority over increment and sets the count to 0.
- Async reset mid-operation: return to RUN immediately, flushes drop, counter cleared.

Test Plan:
- Load-use: ex_load=1, ex_rd=3, id_rn=3, id_rn_valid=1 for 1 cycle -> that cycle en_pc=en_ifid=0, en_idex=1; next cycle STALL with flush_idex=1, en_pc=0; then RUN with all en=1; stall_count=2.
- Masked source: same as load-use but id_rn_valid=0, id_rm=3, id_rm_valid=0 -> no stall, stays RUN.
- Taken branch concurrent with hz: ex_branch_taken=1 and hz=1 -> FLUSH next cycle with flush_ifid=flush_idex=1, en_pc=0; no STALL entered.
- mem_busy for 3 cycles starting in STALL -> STALL flush_idex still 1 that cycle with all en=0; then 3 MEMWAIT cycles all en=0; return to RUN.
- Halt: halt_req=1 in RUN -> halted=1 next cycle, en_pc=0, en_memwb=1; resume=1 -> RUN next cycle, halted=0.
- Saturation and reset: CNT_W=4, hold mem_busy 20 cycles -> stall_count sticks at 15; clr_count=1 -> 0. Pulse reset_n low during FLUSH -> flushes 0 asynchronously, state RUN.
